bcd_convert_arbiter: RTL and testbench
======================================

# bcd_convert_arbiter

Sequential, shared binary-to-BCD converter with a two-requester round-robin front end. It sequences one double-dabble step per clock, so 16-bit values (score, timer, etc.) reach the HEX display drivers without a large combinational tree per display. Requesters hand over a binary value, wait for `done`, then latch the 4-digit BCD result.

## Interface
- `WIDTH`, default 16: binary operand width. Supported range is 8..16; the shift count equals `WIDTH`.
- `clk`, input, 1: system clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, 2: per-requester conversion request. Level-sensitive; must be held until that requester's `grant` bit.
- `bin0`, input, WIDTH: operand of requester 0. Sampled on the grant edge.
- `bin1`, input, WIDTH: operand of requester 1. Sampled on the grant edge.
- `grant`, output, 2: one-cycle pulse. Operand of the indicated requester has been captured.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 2: one-cycle pulse. `bcd` is valid for the indicated requester.
- `bcd`, output, 16: four BCD digits, thousands in [15:12]. Holds its value until the next `done`.
- `ovf`, output, 1: operand exceeded 9999. Updated together with `bcd`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with any `req` bit high:
  - Pick the winner, capture its operand into the shift register.
  - Clear the 20-bit (5-digit) BCD accumulator and set `cnt` to 0.
  - Pulse `grant[winner]`, go to SHIFT.
- IDLE with no request: stay in IDLE.
- Arbitration is round-robin on `last`, the index of the last requester served:
  - If both requests are high, the requester other than `last` wins.
  - If only one request is high, it wins regardless of `last`.
  - `last` updates on grant.
- SHIFT, each cycle:
  - Every accumulator digit ≥5 gets +3 (4-bit, no carry between digits).
  - Then shift {accumulator, operand} left by one; the operand MSB enters accumulator bit 0.
  - `cnt` increments.
- After the `WIDTH`-th shift, go to DONE and register the result onto `bcd` and `ovf`.
- DONE: pulse `done[winner]` for one cycle, then return to IDLE.
- A requester may drop `req` any time after its grant. If `req` is still high in IDLE, it is a new request.
- `req` changes during SHIFT or DONE are ignored. Operands are not re-sampled.
- Reset values:
  - state IDLE, `cnt` 0, `last` 1 (requester 0 wins the first tie).
  - `grant` 0, `done` 0, `busy` 0, `bcd` 16'h0000, `ovf` 0.
- Reset during SHIFT or DONE: the conversion is aborted, no `done` is issued, and all outputs take their reset values.

## Timing
- Request seen in IDLE in cycle T:
  - `grant` high in cycle T+1.
  - SHIFT occupies cycles T+1..T+WIDTH.
  - `done`, with new `bcd`/`ovf`, high in cycle T+WIDTH+1 (T+17 for `WIDTH`=16).
  - IDLE in cycle T+WIDTH+2.
- Earliest next grant is T+WIDTH+3. Throughput is one conversion per WIDTH+2 cycles.
- `bcd` and `ovf` change only on the edge that raises `done`.
- `grant` and `done` are never high in the same cycle. At most one bit of each is high.

## Configuration
- `BCD_OVF_SAT_EN` defined:
  - If the 5th accumulator digit is nonzero, `bcd` is 16'h9999 and `ovf`=1.
  - Otherwise `bcd` is the low 4 digits and `ovf`=0.
- `BCD_OVF_SAT_EN` not defined:
  - `bcd` is always the low 4 digits, i.e. the value mod 10000.
  - `ovf` is tied to 0 and the saturation compare is not built.

## Structure
- Package `bcd_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - `BCD_DIGITS`=4 and `BCD_ACC_DIGITS`=5;
  - the constant `BCD_SAT` = 16'h9999.
- One sub-module, `bcd_dabble_step`: a combinational add-3-if-≥5 applied to a 20-bit accumulator. It is instantiated once and feeds the shift.
- The FSM, counter, arbiter and registers live in `bcd_convert_arbiter`.

## Test plan
- Reset, then `req`=2'b01, `bin0`=1234:
  - `grant`=01 at T+1, `done`=01 at T+17.
  - `bcd`=16'h1234, `ovf`=0.
- `req`=2'b11 held, `bin0`=42, `bin1`=9999:
  - First `done`=01 with `bcd` 16'h0042.
  - Then `grant`=10 at T+19 and `done`=10 at T+35 with `bcd` 16'h9999.
  - A third grant goes to requester 0 (alternation).
- `bin1`=65535:
  - With `BCD_OVF_SAT_EN`: `bcd` 16'h9999, `ovf`=1.
  - Without it: `bcd` 16'h5535, `ovf`=0.
- `bin0`=0 and `bin0`=10000:
  - 0 gives 16'h0000, `ovf`=0.
  - 10000 gives `ovf`=1 when the macro is on, 16'h0000 when it is off.
- Previous result 16'h1234, `reset` pulsed in the 8th SHIFT cycle:
  - No `done` pulse; `bcd` is 16'h0000.
  - A following `req`=01 with `bin0`=7 gives 16'h0007 at the nominal latency.
- `bin0` changed and `req` dropped during SHIFT:
  - Result reflects the captured operand.
  - No extra grant is issued.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t        : controller states (IDLE / SHIFT / DONE)
//   BCD_DIGITS     : digits presented on the bcd output
//   BCD_ACC_DIGITS : digits held in the internal double-dabble accumulator
//   BCD_SAT        : value shown on bcd when an over-range operand saturates
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS     = 4;
    localparam int BCD_ACC_DIGITS = 5;

    localparam logic [4*BCD_DIGITS-1:0] BCD_SAT = 16'h9999;

endpackage

// File: rtl/bcd_dabble_step.sv
// ---------------------------------------------------------------------------
// bcd_dabble_step
// Combinational add-3 correction of one double-dabble iteration: every 4-bit
// digit of the accumulator that is 5 or more gets +3. Digits are corrected
// independently; no carry crosses a digit boundary.
// Ports:
//   acc_i : accumulator before correction (BCD_ACC_DIGITS digits)
//   acc_o : accumulator after correction, ready to be shifted left by one
// ---------------------------------------------------------------------------
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [4*BCD_ACC_DIGITS-1:0] acc_i,
    output logic [4*BCD_ACC_DIGITS-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < BCD_ACC_DIGITS; i++) begin
            if (acc_i[4*i +: 4] >= 4'd5) begin
                acc_o[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_convert_arbiter
// Shared binary-to-BCD converter with a two-requester round-robin front end.
// One double-dabble step runs per clock; a conversion takes WIDTH+2 cycles
// from grant to the cycle after done.
//
// Handshake: a requester holds its req bit until it sees its grant bit
// (one-cycle pulse, operand captured on that edge). It then waits for its
// done bit (one-cycle pulse) and reads bcd/ovf, which hold until the next
// done. req changes outside IDLE are ignored.
//
// Build option: define BCD_OVF_SAT_EN to saturate over-range operands
// (> 9999) to 16'h9999 with ovf=1. Without it, bcd is the value mod 10000
// and ovf is tied low.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset
//   req       : per-requester conversion request (level)
//   bin0/bin1 : operands of requester 0 / 1, sampled on the grant edge
//   grant     : one-hot pulse, operand of that requester captured
//   busy      : high whenever the controller is not IDLE
//   done      : one-hot pulse, bcd/ovf valid for that requester
//   bcd       : four BCD digits, thousands in [15:12]
//   ovf       : operand exceeded 9999 (saturation build only)
//   dbg_state : current controller state, for observation
// ---------------------------------------------------------------------------
module bcd_convert_arbiter
    import bcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req,
    input  logic [WIDTH-1:0]        bin0,
    input  logic [WIDTH-1:0]        bin1,
    output logic [1:0]              grant,
    output logic                    busy,
    output logic [1:0]              done,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    ovf,
    output state_t                  dbg_state
);

    localparam int ACC_W = 4 * BCD_ACC_DIGITS;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = 5;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic               winner_q;
    logic [WIDTH-1:0]   op_q;
    logic [ACC_W-1:0]   acc_q;
    logic [1:0]         grant_q;
    logic [1:0]         done_q;
    logic               busy_q;
    logic [BCD_W-1:0]   bcd_q;

    logic               win;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_d;
    logic [WIDTH-1:0]   op_d;
    logic [BCD_W-1:0]   res_bcd;
    logic               unused_acc_msb;

    // Both requesting: the one not served last wins. Otherwise the only
    // requester present wins.
    always_comb begin
        if (req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = req[1];
        end
    end

    bcd_dabble_step u_step (
        .acc_i (acc_q),
        .acc_o (acc_adj)
    );

    // The top accumulator bit is shifted out; it is always zero for operands
    // up to 16 bits, so it is intentionally dropped.
    assign unused_acc_msb = acc_adj[ACC_W-1];
    assign acc_d          = {acc_adj[ACC_W-2:0], op_q[WIDTH-1]};
    assign op_d           = {op_q[WIDTH-2:0], 1'b0};

`ifdef BCD_OVF_SAT_EN
    logic res_ovf;
    logic ovf_q;

    assign res_ovf = (acc_d[ACC_W-1 -: 4] != 4'd0);
    assign res_bcd = res_ovf ? BCD_SAT : acc_d[BCD_W-1:0];
    assign ovf     = ovf_q;
`else
    assign res_bcd = acc_d[BCD_W-1:0];
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            winner_q <= 1'b0;
            op_q     <= '0;
            acc_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            bcd_q    <= '0;
`ifdef BCD_OVF_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        op_q          <= win ? bin1 : bin0;
                        acc_q         <= '0;
                        cnt_q         <= '0;
                        grant_q[win]  <= 1'b1;
                        last_q        <= win;
                        winner_q      <= win;
                        busy_q        <= 1'b1;
                        state_q       <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    op_q  <= op_d;
                    cnt_q <= cnt_q + 1'b1;
                    // This edge performs the WIDTH-th shift; publish the
                    // shifted result directly so done and bcd rise together.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        bcd_q            <= res_bcd;
`ifdef BCD_OVF_SAT_EN
                        ovf_q            <= res_ovf;
`endif
                        done_q[winner_q] <= 1'b1;
                        state_q          <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign bcd       = bcd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_convert_arbiter
// Self-checking bench for bcd_convert_arbiter (WIDTH=16). Expected digits are
// computed with decimal division; the arbitration winner follows a simple
// "last served" model. Honours BCD_OVF_SAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_bcd_convert_arbiter;
    import bcd_pkg::*;

    localparam int WIDTH = 16;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] bin0;
    logic [15:0] bin1;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  done;
    logic [15:0] bcd;
    logic        ovf;
    state_t      dbg_state;

    int checks;
    int errors;
    int tb_last;
    logic [15:0] tb_bcd;
    logic        tb_ovf;

    bcd_convert_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bin0      (bin0),
        .bin1      (bin1),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ovf, bcd} expected for an operand value
    function automatic logic [16:0] model(input int v);
        int d;
        logic [16:0] r;
        d = v % 10000;
        r = {1'b0, 4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
`ifdef BCD_OVF_SAT_EN
        if (v > 9999) r = {1'b1, 16'h9999};
`endif
        return r;
    endfunction

    // grant/done exclusivity and one-hotness, every cycle
    always @(negedge clk) begin
        checks++;
        if ((grant != 2'b00 && done != 2'b00) || !$onehot0(grant) || !$onehot0(done)) begin
            errors++;
            $display("FAIL exclusivity: grant=%b done=%b at %0t", grant, done, $time);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b00;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        tb_last = 1;
        tb_bcd  = 16'h0000;
        tb_ovf  = 1'b0;
    endtask

    // mode 0: drop req after grant; 1: hold req; 2: drop req and scramble operands
    task automatic do_conv(input logic [1:0] r, input logic [15:0] b0, input logic [15:0] b1,
                           input int mode, input string name);
        int w;
        logic [16:0] e;
        w = (r == 2'b11) ? (1 - tb_last) : ((r == 2'b10) ? 1 : 0);
        e = model(int'(w ? b1 : b0));
        @(negedge clk);
        req  = r;
        bin0 = b0;
        bin1 = b1;
        @(negedge clk);
        checks++;
        if (grant !== 2'(1 << w) || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s grant: got grant=%b busy=%b, want grant=%b busy=1",
                     name, grant, busy, 2'(1 << w));
        end
        tb_last = w;
        if (mode != 1) req = 2'b00;
        for (int k = 2; k <= WIDTH + 1; k++) begin
            @(negedge clk);
            if (mode == 2) begin
                bin0 = 16'($urandom);
                bin1 = 16'($urandom);
            end
            checks++;
            if (k <= WIDTH) begin
                if (done !== 2'b00 || grant !== 2'b00 || busy !== 1'b1 ||
                    bcd !== tb_bcd || ovf !== tb_ovf) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got done=%b grant=%b busy=%b bcd=%h ovf=%b, want done=00 grant=00 busy=1 bcd=%h ovf=%b",
                             name, k, done, grant, busy, bcd, ovf, tb_bcd, tb_ovf);
                end
            end else begin
                if (done !== 2'(1 << w) || bcd !== e[15:0] || ovf !== e[16] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s result: got done=%b bcd=%h ovf=%b busy=%b, want done=%b bcd=%h ovf=%b busy=1",
                             name, done, bcd, ovf, busy, 2'(1 << w), e[15:0], e[16]);
                end
            end
        end
        tb_bcd = e[15:0];
        tb_ovf = e[16];
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || bcd !== 16'h0000 ||
            ovf !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_values: grant=%b done=%b busy=%b bcd=%h ovf=%b state=%0d, want all zero/IDLE",
                     grant, done, busy, bcd, ovf, dbg_state);
        end
        // idle with no request stays idle
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL idle_hold: grant=%b busy=%b state=%0d, want 00/0/IDLE", grant, busy, dbg_state);
        end
    endtask

    task automatic test_basic();
        do_conv(2'b01, 16'd1234, 16'd0, 0, "basic_1234");
    endtask

    task automatic test_back_to_back();
        do_conv(2'b11, 16'd42, 16'd9999, 1, "rr_first");
        do_conv(2'b11, 16'd42, 16'd9999, 1, "rr_second");
        do_conv(2'b11, 16'd42, 16'd9999, 0, "rr_third");
    endtask

    task automatic test_boundaries();
        do_conv(2'b10, 16'd0, 16'd65535, 0, "max_65535");
        do_conv(2'b01, 16'd0, 16'd0, 0, "zero");
        do_conv(2'b01, 16'd10000, 16'd0, 0, "ten_thousand");
        do_conv(2'b10, 16'd0, 16'd9999, 0, "max_in_range");
    endtask

    task automatic test_abort();
        do_conv(2'b01, 16'd1234, 16'd0, 0, "pre_abort");
        @(negedge clk);
        req  = 2'b01;
        bin0 = 16'd5555;
        @(negedge clk);   // first SHIFT cycle
        req = 2'b00;
        repeat (7) @(negedge clk);   // eighth SHIFT cycle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: grant=%b done=%b busy=%b bcd=%h ovf=%b, want 00/00/0/0000/0",
                     grant, done, busy, bcd, ovf);
        end
        tb_last = 1;
        tb_bcd  = 16'h0000;
        tb_ovf  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 2'b00 || bcd !== 16'h0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: cycle %0d done=%b bcd=%h busy=%b, want 00/0000/0", k, done, bcd, busy);
            end
        end
        do_conv(2'b01, 16'd7, 16'd0, 0, "post_abort_7");
    endtask

    task automatic test_operand_change();
        do_conv(2'b01, 16'd8765, 16'd4321, 2, "scramble_r0");
        do_conv(2'b10, 16'd1111, 16'd2468, 2, "scramble_r1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_conv(2'($urandom_range(1, 3)), 16'($urandom_range(0, 65535)),
                    16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 2'b00;
        bin0   = '0;
        bin1   = '0;
        tb_last = 1;
        tb_bcd  = 16'h0000;
        tb_ovf  = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundaries();
        test_abort();
        test_operand_change();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
